// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: host writes bytes into a FIFO and the FSM serialises them
// (start, LSB-first data, stop bits), chaining queued frames with no idle gap.
module uart_tx_fifo #(
  parameter int CLK_HZ       = 12_000_000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            wr_en,
  input  logic [PAYLOAD_BITS-1:0]         wr_data,
  output logic                            full,
  output logic                            empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
  output logic                            overflow,
  output logic                            busy,
  output logic                            uart_txd
);

  localparam int CPB      = CLK_HZ / BIT_RATE;
  localparam int STOP_CYC = STOP_BITS * CPB;
  localparam int CW       = $clog2(STOP_CYC + 1);
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int NW       = $clog2(FIFO_DEPTH + 1);
  localparam int BW       = $clog2(PAYLOAD_BITS + 1);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_CYC - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(PAYLOAD_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                  state, state_n;
  logic [CW-1:0]           cyc, cyc_n;
  logic [BW-1:0]           bit_idx, bit_n;
  logic [PAYLOAD_BITS-1:0] shift, shift_n;
  logic                    txd_n;
  logic                    pop;
  logic                    wr_ok;

  logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [PAYLOAD_BITS-1:0] head;

  assign full  = (count == NW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign wr_ok = wr_en && !full;
  assign head  = mem[rd_ptr];
  assign busy  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // A pop in the same cycle never frees space for a write: wr_ok uses pre-edge full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_en && full;
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, pop})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cyc      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      uart_txd <= 1'b1;
    end else begin
      state    <= state_n;
      cyc      <= cyc_n;
      bit_idx  <= bit_n;
      shift    <= shift_n;
      uart_txd <= txd_n;
    end
  end

  // txd_n is the line level for the state being entered, so the output stays a pure flop.
  always_comb begin
    state_n = state;
    cyc_n   = cyc;
    bit_n   = bit_idx;
    shift_n = shift;
    txd_n   = uart_txd;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        txd_n = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_n = head;
          cyc_n   = '0;
          state_n = START;
          txd_n   = 1'b0;
        end
      end
      START: begin
        if (cyc == BIT_LAST) begin
          cyc_n   = '0;
          bit_n   = '0;
          state_n = DATA;
          txd_n   = shift[0];
        end else begin
          cyc_n = cyc + CW'(1);
        end
      end
      DATA: begin
        if (cyc == BIT_LAST) begin
          cyc_n = '0;
          if (bit_idx == DATA_LAST) begin
            state_n = STOP;
            txd_n   = 1'b1;
          end else begin
            bit_n   = bit_idx + BW'(1);
            shift_n = shift >> 1;
            txd_n   = shift_n[0];
          end
        end else begin
          cyc_n = cyc + CW'(1);
        end
      end
      STOP: begin
        if (cyc == STOP_LAST) begin
          cyc_n = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_n = head;
            state_n = START;
            txd_n   = 1'b0;
          end else begin
            state_n = IDLE;
            txd_n   = 1'b1;
          end
        end else begin
          cyc_n = cyc + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        txd_n   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a frame-timeline reference model checked every cycle, a vector
// table for a single frame, directed corner sequences, and a 7-bit/2-stop instance.
module tb_uart_tx_fifo;

  localparam int C = 10;
  localparam int P = 8;
  localparam int S = 1;
  localparam int D = 16;
  localparam int F = (1 + P + S) * C;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       full, empty, overflow, busy, uart_txd;
  logic [4:0] count;

  logic       wr_en2 = 1'b0;
  logic [6:0] wr_data2 = '0;
  logic       full2, empty2, overflow2, busy2, txd2;
  logic [4:0] count2;

  uart_tx_fifo #(.CLK_HZ(1_000_000), .BIT_RATE(100_000), .PAYLOAD_BITS(8),
                 .STOP_BITS(1), .FIFO_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .empty(empty), .count(count), .overflow(overflow), .busy(busy), .uart_txd(uart_txd));

  uart_tx_fifo #(.CLK_HZ(1_000_000), .BIT_RATE(100_000), .PAYLOAD_BITS(7),
                 .STOP_BITS(2), .FIFO_DEPTH(16)) dut2 (
    .clk(clk), .reset(reset), .wr_en(wr_en2), .wr_data(wr_data2), .full(full2),
    .empty(empty2), .count(count2), .overflow(overflow2), .busy(busy2), .uart_txd(txd2));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: queue of accepted bytes plus position inside the frame on the line.
  logic [7:0] q[$];
  bit         m_act;
  int         m_t;
  logic [7:0] m_fb;
  bit         m_ovf;

  function automatic logic m_txd();
    int idx;
    if (!m_act) return 1'b1;
    idx = m_t / C;
    if (idx == 0) return 1'b0;
    if (idx <= P) return m_fb[idx-1];
    return 1'b1;
  endfunction

  task automatic model_clear();
    q.delete();
    m_act = 0;
    m_t   = 0;
    m_fb  = '0;
    m_ovf = 0;
  endtask

  task automatic model_step(input bit we, input logic [7:0] d);
    bit nonempty, is_full, do_pop;
    nonempty = (q.size() > 0);
    is_full  = (q.size() == D);
    m_ovf    = we && is_full;
    do_pop   = 0;
    if (m_act) begin
      if (m_t == F - 1) begin
        if (nonempty) begin do_pop = 1; m_t = 0; end
        else m_act = 0;
      end else begin
        m_t++;
      end
    end else if (nonempty) begin
      do_pop = 1; m_act = 1; m_t = 0;
    end
    if (do_pop) m_fb = q.pop_front();
    if (we && !is_full) q.push_back(d);
  endtask

  task automatic cycle(input bit we, input logic [7:0] d);
    logic [9:0] exp;
    wr_en   = we;
    wr_data = d;
    @(posedge clk);
    if (reset) model_clear();
    else model_step(we, d);
    @(negedge clk);
    wr_en = 1'b0;
    exp = {m_txd(), m_act, 5'(q.size()), q.size() == D, q.size() == 0, m_ovf};
    check("outputs{txd,busy,count,full,empty,ovf}",
          32'({uart_txd, busy, count, full, empty, overflow}), 32'(exp));
  endtask

  task automatic run_until_idle(input int max_cycles);
    int n = 0;
    do begin
      cycle(1'b0, 8'h00);
      n++;
    end while ((busy || !empty) && n < max_cycles);
    check("drain_timeout", 32'(n < max_cycles), 32'd1);
  endtask

  typedef struct {
    bit         we;
    logic [7:0] d;
    int         adv;
    logic       txd;
    logic       busy;
    logic [4:0] cnt;
  } vec_t;

  vec_t tbl[15];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int bcount, ovf_cnt, max_cnt, guard;

    // Single 0x55 frame: offsets counted in clocks after the write edge.
    tbl[0]  = '{1'b1, 8'h55, 1, 1'b1, 1'b0, 5'd1};
    tbl[1]  = '{1'b0, 8'h00, 1, 1'b0, 1'b1, 5'd0};
    tbl[2]  = '{1'b0, 8'h00, 9, 1'b0, 1'b1, 5'd0};
    tbl[3]  = '{1'b0, 8'h00, 1, 1'b1, 1'b1, 5'd0};
    tbl[4]  = '{1'b0, 8'h00, 10, 1'b0, 1'b1, 5'd0};
    tbl[5]  = '{1'b0, 8'h00, 10, 1'b1, 1'b1, 5'd0};
    tbl[6]  = '{1'b0, 8'h00, 10, 1'b0, 1'b1, 5'd0};
    tbl[7]  = '{1'b0, 8'h00, 10, 1'b1, 1'b1, 5'd0};
    tbl[8]  = '{1'b0, 8'h00, 10, 1'b0, 1'b1, 5'd0};
    tbl[9]  = '{1'b0, 8'h00, 10, 1'b1, 1'b1, 5'd0};
    tbl[10] = '{1'b0, 8'h00, 10, 1'b0, 1'b1, 5'd0};
    tbl[11] = '{1'b0, 8'h00, 9, 1'b0, 1'b1, 5'd0};
    tbl[12] = '{1'b0, 8'h00, 1, 1'b1, 1'b1, 5'd0};
    tbl[13] = '{1'b0, 8'h00, 9, 1'b1, 1'b1, 5'd0};
    tbl[14] = '{1'b0, 8'h00, 1, 1'b1, 1'b0, 5'd0};

    model_clear();
    @(negedge clk);
    cycle(1'b0, 8'h00);
    check("reset_state", 32'({uart_txd, busy, count, full, empty, overflow}),
          32'({1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0}));
    reset = 1'b0;
    repeat (3) cycle(1'b0, 8'h00);

    // Test 1: table-driven single frame
    for (int i = 0; i < 15; i++) begin
      for (int j = 0; j < tbl[i].adv; j++)
        cycle(j == 0 ? tbl[i].we : 1'b0, tbl[i].d);
      check($sformatf("tbl[%0d].txd", i), 32'(uart_txd), 32'(tbl[i].txd));
      check($sformatf("tbl[%0d].busy", i), 32'(busy), 32'(tbl[i].busy));
      check($sformatf("tbl[%0d].count", i), 32'(count), 32'(tbl[i].cnt));
    end
    repeat (5) cycle(1'b0, 8'h00);

    // Test 2: three back-to-back frames
    bcount = 0;
    cycle(1'b1, 8'h00); bcount += int'(busy);
    cycle(1'b1, 8'hFF); bcount += int'(busy);
    cycle(1'b1, 8'hA5); bcount += int'(busy);
    guard = 0;
    while (busy && guard < 400) begin
      cycle(1'b0, 8'h00);
      bcount += int'(busy);
      guard++;
    end
    check("t2_busy_cycles", 32'(bcount), 32'd300);
    check("t2_empty", 32'(empty), 32'd1);

    // Test 3: 20-byte burst overfills the FIFO
    ovf_cnt = 0;
    max_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 8'(i));
      ovf_cnt += int'(overflow);
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
    cycle(1'b0, 8'h00);
    ovf_cnt += int'(overflow);
    check("t3_overflow_pulses", 32'(ovf_cnt), 32'd3);
    check("t3_max_count", 32'(max_cnt), 32'd16);

    // Test 4: rejected write on the same edge as a pop
    guard = 0;
    while (guard < 1000) begin
      if (q.size() < D) cycle(1'b1, 8'($urandom));
      else if (m_act && m_t == F - 1) break;
      else cycle(1'b0, 8'h00);
      guard++;
    end
    check("t4_reach_full_pop", 32'(guard < 1000), 32'd1);
    check("t4_full_before", 32'(full), 32'd1);
    cycle(1'b1, 8'hEE);
    check("t4_overflow", 32'(overflow), 32'd1);
    check("t4_count", 32'(count), 32'd15);
    cycle(1'b0, 8'h00);
    check("t4_overflow_one_cycle", 32'(overflow), 32'd0);
    run_until_idle(2000);

    // Test 5: asynchronous reset in the middle of a frame
    cycle(1'b1, 8'h96);
    cycle(1'b1, 8'h11);
    cycle(1'b1, 8'h22);
    guard = 0;
    while (!(m_act && m_t == 35) && guard < 200) begin
      cycle(1'b0, 8'h00);
      guard++;
    end
    check("t5_reach_cycle35", 32'(guard < 200), 32'd1);
    reset = 1'b1;
    #1;
    check("t5_async", 32'({uart_txd, busy, count, empty}), 32'({1'b1, 1'b0, 5'd0, 1'b1}));
    cycle(1'b0, 8'h00);
    reset = 1'b0;
    cycle(1'b1, 8'h3C);
    cycle(1'b0, 8'h00);
    check("t5_start_after_reset", 32'(uart_txd), 32'd0);
    run_until_idle(300);

    // Randomised bursts and silences against the model
    for (int i = 0; i < 3000; i++) begin
      if ((i % 1000) < 300) cycle(1'($urandom_range(0, 1)), 8'($urandom));
      else cycle(($urandom_range(0, 99) < 3), 8'($urandom));
    end
    run_until_idle(2000);

    // Test 6: 7 data bits, 2 stop bits, two 0x7F frames
    wr_en2 = 1'b1; wr_data2 = 7'h7F;
    cycle(1'b0, 8'h00);
    check("t6_wait", 32'({txd2, busy2}), 32'({1'b1, 1'b0}));
    wr_en2 = 1'b1; wr_data2 = 7'h7F;
    for (int j = 0; j < 200; j++) begin
      cycle(1'b0, 8'h00);
      wr_en2 = 1'b0;
      check($sformatf("t6_txd_%0d", j), 32'(txd2), 32'(((j % 100) / 10) != 0));
      check($sformatf("t6_busy_%0d", j), 32'(busy2), 32'd1);
    end
    cycle(1'b0, 8'h00);
    check("t6_done", 32'({txd2, busy2, empty2}), 32'({1'b1, 1'b0, 1'b1}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
